// File: rtl/systolic_pkg.sv
// Shared types and constants for the output-stationary systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_KW         = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: signed MAC into a wrapping accumulator, with a/b forwarded
// right/down through single registers.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic [DATA_WIDTH-1:0]          a_q;
  logic [DATA_WIDTH-1:0]          b_q;

  // Full-precision product, sign-extended into the accumulator; overflow wraps.
  assign prod_d = $signed(a_i) * $signed(b_i);
  assign acc_d  = clr_i ? '0 : acc_q + ACC_WIDTH'(prod_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_engine.sv
// N x M output-stationary systolic matrix-multiply engine: operand skew chains, PE grid,
// and the IDLE/FEED/FLUSH/DRAIN/DONE sequencer with a back-pressured row-major drain.
module systolic_array_engine
  import systolic_pkg::*;
#(
  parameter int N          = 3,
  parameter int M          = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_MAX      = 255,
  parameter int KW         = DEF_KW,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  localparam int RW        = (N > 1) ? clog2(N) : 1,
  localparam int CW        = (M > 1) ? clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    op_rd_en,
  input  logic [N*DATA_WIDTH-1:0] a_in,
  input  logic [M*DATA_WIDTH-1:0] b_in,
  output logic                    c_valid,
  input  logic                    c_ready,
  output logic [ACC_WIDTH-1:0]    c_data,
  output logic [RW-1:0]           c_row,
  output logic [CW-1:0]           c_col
);

  localparam int KCW = (clog2(K_MAX + 1) > KW) ? clog2(K_MAX + 1) : KW;
  localparam int FW  = clog2(N + M);

  state_t                  state_q;
  logic [KCW-1:0]          k_rem_q;
  logic [FW-1:0]           fl_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    op_rd_en_q;
  logic                    c_valid_q;
  logic [ACC_WIDTH-1:0]    c_data_q;
  logic [RW-1:0]           c_row_q;
  logic [CW-1:0]           c_col_q;

  logic                    acc_clr;
  logic                    last_d;
  logic [RW-1:0]           nrow_d;
  logic [CW-1:0]           ncol_d;
  logic [ACC_WIDTH-1:0]    nxt_data_d;

  logic [DATA_WIDTH-1:0]   a_edge [N];
  logic [DATA_WIDTH-1:0]   b_edge [M];
  logic [DATA_WIDTH-1:0]   a_fwd  [N][M];
  logic [DATA_WIDTH-1:0]   b_fwd  [N][M];
  logic [ACC_WIDTH-1:0]    acc_g  [N][M];
  logic [N-1:0]            unused_a;
  logic [M-1:0]            unused_b;

  assign acc_clr = (state_q == ST_IDLE) && start;

  // Row i of A is delayed by i cycles so its wavefront meets column j of B on the diagonal.
  for (genvar i = 0; i < N; i++) begin : g_askew
    logic [DATA_WIDTH-1:0] src;
    assign src = op_rd_en_q ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = src;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] sk_q [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) sk_q[s] <= '0;
        end else begin
          sk_q[0] <= src;
          for (int s = 1; s < i; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign a_edge[i] = sk_q[i-1];
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_bskew
    logic [DATA_WIDTH-1:0] src;
    assign src = op_rd_en_q ? b_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j] = src;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] sk_q [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < j; s++) sk_q[s] <= '0;
        end else begin
          sk_q[0] <= src;
          for (int s = 1; s < j; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign b_edge[j] = sk_q[j-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_pe;
      logic [DATA_WIDTH-1:0] b_pe;
      if (j == 0) begin : g_al
        assign a_pe = a_edge[i];
      end else begin : g_af
        assign a_pe = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_pe = b_edge[j];
      end else begin : g_bf
        assign b_pe = b_fwd[i-1][j];
      end
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr_i(acc_clr),
        .a_i  (a_pe),
        .b_i  (b_pe),
        .a_o  (a_fwd[i][j]),
        .b_o  (b_fwd[i][j]),
        .acc_o(acc_g[i][j])
      );
    end
    assign unused_a[i] = ^a_fwd[i][M-1];
  end

  for (genvar j = 0; j < M; j++) begin : g_bsink
    assign unused_b[j] = ^b_fwd[N-1][j];
  end

  always_comb begin
    last_d     = (c_row_q == RW'(N-1)) && (c_col_q == CW'(M-1));
    nrow_d     = c_row_q;
    ncol_d     = c_col_q + 1'b1;
    nxt_data_d = '0;
    if (c_col_q == CW'(M-1)) begin
      nrow_d = c_row_q + 1'b1;
      ncol_d = '0;
    end
    if (!last_d) nxt_data_d = acc_g[nrow_d][ncol_d];
  end

  // Sequencer: all handshake outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_rem_q    <= '0;
      fl_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_rd_en_q <= 1'b0;
      c_valid_q  <= 1'b0;
      c_data_q   <= '0;
      c_row_q    <= '0;
      c_col_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            k_rem_q  <= KCW'(k_len);
            fl_cnt_q <= '0;
            if (k_len == '0) begin
              state_q <= ST_FLUSH;
            end else begin
              state_q    <= ST_FEED;
              op_rd_en_q <= 1'b1;
            end
          end
        end
        ST_FEED: begin
          if (k_rem_q == KCW'(1)) begin
            state_q    <= ST_FLUSH;
            op_rd_en_q <= 1'b0;
          end
          k_rem_q <= k_rem_q - 1'b1;
        end
        ST_FLUSH: begin
          // Last product reaches the far corner PE one cycle before this counter expires.
          if (fl_cnt_q == FW'(N + M - 2)) begin
            state_q   <= ST_DRAIN;
            c_valid_q <= 1'b1;
            c_data_q  <= acc_g[0][0];
            c_row_q   <= '0;
            c_col_q   <= '0;
          end
          fl_cnt_q <= fl_cnt_q + 1'b1;
        end
        ST_DRAIN: begin
          if (c_ready) begin
            if (last_d) begin
              state_q   <= ST_DONE;
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              c_data_q <= nxt_data_d;
              c_row_q  <= nrow_d;
              c_col_q  <= ncol_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign op_rd_en = op_rd_en_q;
  assign c_valid  = c_valid_q;
  assign c_data   = c_data_q;
  assign c_row    = c_row_q;
  assign c_col    = c_col_q;

endmodule
